// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module  : program_loader_pkg
// Purpose : Shared types and constants for the program loading path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package program_loader_pkg;

    localparam int DATA_W = 8;

    // HLT occupies the upper nibble; driving it keeps the sequencer inert on underflow
    localparam logic [3:0] HLT_OPCODE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PROGRAM = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_e;

endpackage

`default_nettype wire

// File: rtl/program_fifo.sv
// ============================================================================
// Module  : program_fifo
// Purpose : Image buffer; circular store with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module program_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] rptr_q;
    logic [ADDR_W:0]   count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module  : program_loader
// Purpose : Buffers a host program image, then feeds it to the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W = program_loader_pkg::DATA_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] ui_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              read_ui_in,
    input  logic              done_load,
    output logic              programming,
    output logic [DATA_W-1:0] prog_data,
    output logic              prog_data_oe,
    output logic [ADDR_W:0]   loaded_cnt,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] FILL_BYTE = {HLT_OPCODE, {(DATA_W-4){1'b0}}};

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   loaded_cnt_q, loaded_cnt_d;
    logic              err_q, err_d;

    logic              fifo_clr;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;

    program_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (fifo_clr),
        .push   (fifo_push),
        .din    (ui_in),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            loaded_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_cnt_q <= loaded_cnt_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        loaded_cnt_d = loaded_cnt_q;
        err_d        = err_q;
        fifo_clr     = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        in_ready     = 1'b0;
        programming  = 1'b0;
        prog_data    = '0;
        prog_data_oe = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FILL;
                    fifo_clr     = 1'b1;
                    loaded_cnt_d = '0;
                    err_d        = 1'b0;
                end
            end
            ST_FILL: begin
                in_ready  = !fifo_full;
                fifo_push = in_valid && !fifo_full;
                if (fifo_push && (fifo_count == LAST_CNT)) begin
                    state_d = ST_PROGRAM;
                end
            end
            ST_PROGRAM: begin
                programming  = 1'b1;
                prog_data_oe = read_ui_in;
                prog_data    = fifo_empty ? FILL_BYTE : fifo_dout;
                if (read_ui_in) begin
                    if (fifo_empty) begin
                        err_d = 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end
                // Leaving on the final RAM write lets the PC wrap to 0 under T5
                if (done_load) begin
                    loaded_cnt_d = loaded_cnt_q + CNT_ONE;
                    if (loaded_cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign loaded_cnt = loaded_cnt_q;
    assign err        = err_q;
    assign busy       = (state_q == ST_FILL) || (state_q == ST_PROGRAM);

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module  : tb_program_loader
// Purpose : Self-checking bench for program_loader against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              resetn;
    logic              start;
    logic [DATA_W-1:0] ui_in;
    logic              in_valid;
    logic              in_ready;
    logic              read_ui_in;
    logic              done_load;
    logic              programming;
    logic [DATA_W-1:0] prog_data;
    logic              prog_data_oe;
    logic [ADDR_W:0]   loaded_cnt;
    logic              busy;
    logic              err;

    int n_vec;
    int n_err;

    // Reference model: the image as the host delivered it, plus session counters
    logic [DATA_W-1:0] model_q[$];
    int                model_loaded;
    bit                model_err;

    program_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .ui_in        (ui_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .read_ui_in   (read_ui_in),
        .done_load    (done_load),
        .programming  (programming),
        .prog_data    (prog_data),
        .prog_data_oe (prog_data_oe),
        .loaded_cnt   (loaded_cnt),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        in_valid   = 1'b0;
        read_ui_in = 1'b0;
        done_load  = 1'b0;
        ui_in      = '0;
    endtask

    task automatic check_quiet(input string tag, input int exp_cnt);
        check({tag, "_prog"}, programming, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_oe"}, prog_data_oe, 0);
        check({tag, "_data"}, prog_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cnt"}, loaded_cnt, exp_cnt);
        check({tag, "_err"}, err, model_err);
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_q.delete();
        model_loaded = 0;
        model_err    = 1'b0;
        #1;
        check("start_busy", busy, 1);
        check("start_cnt", loaded_cnt, 0);
        check("start_err", err, 0);
    endtask

    // mode 0: valid held, 1: valid on odd cycles, 2: random valid
    task automatic fill_image(input int mode, input bit seq_bytes, input bit noise, output int cycles);
        int          pushed;
        logic [7:0]  nxt;
        pushed = 0;
        cycles = 0;
        nxt    = seq_bytes ? 8'h40 : 8'($urandom);
        while (pushed < DEPTH && cycles < 200) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cycles % 2) == 1;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            ui_in      = nxt;
            start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            read_ui_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            done_load  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            check("fill_rdy", in_ready, 1);
            check("fill_prog", programming, 0);
            check("fill_oe", prog_data_oe, 0);
            check("fill_cnt", loaded_cnt, 0);
            if (in_valid) begin
                model_q.push_back(nxt);
                pushed++;
                nxt = seq_bytes ? nxt + 8'h01 : 8'($urandom);
            end
            cycles++;
            tick();
        end
        if (pushed < DEPTH) check("fill_timeout", pushed, DEPTH);
        idle_inputs();
        #1;
        check("fill_to_prog", programming, 1);
        check("fill_rdy_low", in_ready, 0);
        check("fill_busy", busy, 1);
    endtask

    // abort_after: reset after this many done_load pulses (0 = never)
    task automatic program_image(input bit underflow, input bit noise, input int abort_after);
        for (int k = 0; k < DEPTH; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                #1;
                check("gap_prog", programming, 1);
                check("gap_oe", prog_data_oe, 0);
                tick();
            end
            start      = 1'b0;
            read_ui_in = 1'b1;
            #1;
            check("rd_data", prog_data, model_q.size() > 0 ? model_q[0] : 0);
            check("rd_oe", prog_data_oe, 1);
            tick();
            read_ui_in = 1'b0;
            if (model_q.size() > 0) void'(model_q.pop_front());
            if (underflow && k == DEPTH - 1) begin
                read_ui_in = 1'b1;
                #1;
                check("uf_data", prog_data, 0);
                check("uf_oe", prog_data_oe, 1);
                tick();
                read_ui_in = 1'b0;
                model_err  = 1'b1;
                #1;
                check("uf_err", err, 1);
                check("uf_data_after", prog_data, 0);
            end
            done_load = 1'b1;
            #1;
            check("dl_cnt_before", loaded_cnt, model_loaded);
            tick();
            done_load = 1'b0;
            model_loaded++;
            #1;
            check("dl_cnt", loaded_cnt, model_loaded);
            check("dl_prog", programming, model_loaded < DEPTH);
            check("dl_err", err, model_err);
            if (abort_after != 0 && model_loaded == abort_after) begin
                resetn = 1'b0;
                #1;
                model_q.delete();
                model_loaded = 0;
                model_err    = 1'b0;
                check_quiet("abort", 0);
                #2;
                resetn = 1'b1;
                tick();
                check_quiet("abort_idle", 0);
                return;
            end
        end
        check_quiet("done", DEPTH);
        tick();
        check_quiet("idle_after", DEPTH);
    endtask

    initial begin
        int cyc;
        n_vec = 0;
        n_err = 0;
        model_loaded = 0;
        model_err    = 1'b0;
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset", 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            read_ui_in = 1'($urandom_range(0, 1));
            done_load  = 1'($urandom_range(0, 1));
            #1;
            check_quiet("idle_strobe", 0);
            tick();
        end
        idle_inputs();

        start_session();
        fill_image(0, 1'b1, 1'b0, cyc);
        check("nominal_fill_cycles", cyc, DEPTH);
        program_image(1'b0, 1'b0, 0);

        start_session();
        fill_image(1, 1'b0, 1'b0, cyc);
        check("backpressure_cycles", cyc, 2 * DEPTH);
        program_image(1'b0, 1'b0, 0);

        start_session();
        fill_image(2, 1'b0, 1'b0, cyc);
        program_image(1'b1, 1'b0, 0);
        check("err_sticky_idle", err, 1);

        start_session();
        fill_image(2, 1'b0, 1'b1, cyc);
        program_image(1'b0, 1'b1, 7);

        start_session();
        fill_image(0, 1'b0, 1'b1, cyc);
        program_image(1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Front end of the programming path, directly upstream of the control sequencer's programming mode.
- Accepts a program image byte-by-byte from the host pins through a valid/ready handshake and buffers the full image in an internal FIFO.
- Once the image is buffered, asserts `programming` and presents one byte per sequencer loop on the bus. It pops a byte on each `read_ui_in` and counts `done_load` pulses.
- Releases `programming` after the last RAM write, so the PC has wrapped to 0 and execution begins.

Parameters:
- DATA_W, 8, width of a program byte and of the bus.
- DEPTH, 16, bytes per program image (RAM size); must be a power of two.
- ADDR_W, 4, log2(DEPTH); width of FIFO pointers.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session from IDLE.
- ui_in  input  DATA_W  host program byte.
- in_valid  input  1  host byte valid.
- in_ready  output  1  loader accepts byte this cycle.
- read_ui_in  input  1  sequencer T3 request; the bus byte is consumed at this posedge.
- done_load  input  1  sequencer T4 pulse; RAM write of the current byte has completed.
- programming  output  1  to sequencer; selects programming micro-ops.
- prog_data  output  DATA_W  byte driven onto the bus.
- prog_data_oe  output  1  bus drive enable; equals read_ui_in while in PROGRAM.
- loaded_cnt  output  ADDR_W+1  number of done_load pulses in the current session (0..DEPTH).
- busy  output  1  high in FILL or PROGRAM.
- err  output  1  sticky underflow flag; cleared by start or reset.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; FIFO empty; pointers=0; loaded_cnt=0.
  - programming=0, in_ready=0, prog_data_oe=0, prog_data=0, busy=0, err=0.
- States: IDLE, FILL, PROGRAM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> FILL; FIFO cleared, loaded_cnt=0, err=0.
- FILL:
  - in_ready = !full.
  - Push on in_valid && in_ready; byte captured at that posedge.
  - When the push making count==DEPTH occurs -> PROGRAM at the same posedge, so programming=1 from the next cycle.
  - start ignored.
- PROGRAM:
  - programming=1, in_ready=0.
  - prog_data = FIFO head, combinational. prog_data_oe = read_ui_in.
  - Pop at posedge when read_ui_in=1 and FIFO non-empty.
  - read_ui_in while empty: prog_data=0x00 (HLT opcode), no pop, err<=1.
  - Each posedge with done_load=1 increments loaded_cnt.
  - When done_load=1 and loaded_cnt==DEPTH-1: loaded_cnt<=DEPTH, state<=DONE, programming drops next cycle. The sequencer is then in T5, where programming has no effect.
- DONE:
  - programming=0; loaded_cnt holds DEPTH.
  - Next cycle -> IDLE. loaded_cnt is retained until the next start.
- Outside PROGRAM: read_ui_in and done_load are ignored (no pop, no count, prog_data_oe=0).
- read_ui_in and done_load are never simultaneously high (sequencer T3 vs T4). If they are, both actions are taken.
- FIFO:
  - DEPTH entries; ADDR_W-bit read/write pointers, wrapping modulo DEPTH.
  - Count is ADDR_W+1 bits; full when count==DEPTH, empty when count==0.
  - Push and pop are never concurrent in this block. The FIFO still supports a concurrent push and pop: the count is unchanged.
- Reset asserted mid-session aborts immediately; programming falls asynchronously with resetn.

Decomposition:
- Shared package holds:
  - the loader state encoding (IDLE=0, FILL=1, PROGRAM=2, DONE=3);
  - DATA_W;
  - the HLT opcode constant 4'h0 used for the underflow fill byte (0x00).
- One sub-module: `program_fifo` (parameterised DATA_W/DEPTH/ADDR_W). Ports: clk, resetn, clr, push, din, pop, dout, full, empty, count.
- `program_loader` holds the FSM, loaded_cnt, err and bus-drive logic.

Test Plan:
- Nominal load: start, then 16 bytes 0x40..0x4F with in_valid held.
  - in_ready drops after the 16th byte; programming=1 the next cycle.
  - Across 16 read_ui_in/done_load pairs, prog_data sequence = 0x40..0x4F.
  - loaded_cnt=16, programming=0, state IDLE after DONE.
- Host backpressure: in_valid toggles every other cycle during FILL.
  - Exactly 16 pushes; no byte duplicated or lost; FILL lasts 32 cycles.
- Underflow: force an extra read_ui_in in PROGRAM after 16 pops (stub sequencer).
  - prog_data=0x00, err=1, FIFO pointers unchanged.
  - A following start clears err.
- Spurious strobes: read_ui_in and done_load pulsed in IDLE and FILL.
  - No pop, loaded_cnt=0, prog_data_oe=0.
- Reset mid-PROGRAM after 7 done_load pulses: drop resetn.
  - programming=0 immediately (async); loaded_cnt=0; FIFO empty.
  - A new session loads 16 fresh bytes correctly.
- start during FILL or PROGRAM: ignored.
  - Byte order and loaded_cnt are unaffected; session completes at 16.
